// File: rtl/team_06_sample_history.sv
// team_06_sample_history
//
// Circular sample-history buffer serving the echo effect's past-sample
// requests. Every save_en cycle stores one 8-bit sample; a search returns the
// sample written `offset` samples before the newest one, one cycle later.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   save_audio   sample to store
//   save_en      write strobe, one sample per cycle high
//   flush        discard history (pointer and fill count to 0)
//   search       read request, sampled every cycle
//   offset       samples back from newest (0 = most recent write)
//   past_output  read data, holds its value between reads
//   past_valid   one-cycle pulse per accepted search
//   full         DEPTH samples held since reset or flush
//   fill_count   samples held, saturating at DEPTH
//
// Configuration:
//   TEAM_06_HISTORY_ZERO_FILL_EN  when defined, reads with offset >= fill
//   return 8'h00; when undefined, reads return the raw memory word at the
//   computed address regardless of how much history exists.

module team_06_sample_history #(
  parameter int DEPTH    = 8192,
  parameter int OFFSET_W = 13,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          save_audio,
  input  logic                save_en,
  input  logic                flush,
  input  logic                search,
  input  logic [OFFSET_W-1:0] offset,
  output logic [7:0]          past_output,
  output logic                past_valid,
  output logic                full,
  output logic [ADDR_W:0]     fill_count
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL
  } fill_state_t;

  localparam logic [ADDR_W:0]   FILL_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   FILL_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   fill;
  logic [ADDR_W:0]   fill_next;
  logic [7:0]        rd_data;
  fill_state_t       state;

  // A flush restarts history at address 0, so a concurrent write lands there.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that skips the assignment would infer a latch.
    wr_addr   = flush ? '0 : wr_ptr;
    fill_next = fill;
    if (flush) begin
      fill_next = save_en ? FILL_ONE : '0;
    end else if (save_en && (fill != FILL_MAX)) begin
      fill_next = fill + FILL_ONE;
    end
  end

  // Newest sample sits at wr_ptr-1; the subtraction wraps modulo DEPTH.
  assign rd_addr = wr_ptr - PTR_ONE - ADDR_W'(offset);

`ifdef TEAM_06_HISTORY_ZERO_FILL_EN
  localparam int CMP_W = (OFFSET_W > ADDR_W + 1) ? OFFSET_W : ADDR_W + 1;

  logic hit;

  // Anything older than the held history reads as silence.
  assign hit     = CMP_W'(offset) < CMP_W'(fill);
  assign rd_data = hit ? mem[rd_addr] : 8'h00;
`else
  assign rd_data = mem[rd_addr];
`endif

  // NOTE: the sample memory has no reset; clearing it would prevent RAM
  // inference, and history is invalidated through fill instead.
  always_ff @(posedge clk) begin
    if (rst && save_en) begin
      mem[wr_addr] <= save_audio;
    end
  end

  // Pointer, fill count and fill state machine.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from the start of the cycle.
    if (!rst) begin
      wr_ptr <= '0;
      fill   <= '0;
      state  <= ST_EMPTY;
    end else begin
      if (save_en) begin
        wr_ptr <= wr_addr + PTR_ONE;
      end else if (flush) begin
        wr_ptr <= '0;
      end
      fill <= fill_next;

      case (state)
        ST_EMPTY: begin
          if (save_en) begin
            state <= (fill_next == FILL_MAX) ? ST_FULL : ST_FILLING;
          end
        end
        ST_FILLING: begin
          if (flush && !save_en) begin
            state <= ST_EMPTY;
          end else if (fill_next == FILL_MAX) begin
            state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (flush) begin
            if (!save_en) begin
              state <= ST_EMPTY;
            end else begin
              state <= (FILL_ONE == FILL_MAX) ? ST_FULL : ST_FILLING;
            end
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  // Read port: the memory is read before this edge's write lands, so a
  // same-cycle write is never visible and flush still reads old history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      past_output <= 8'h00;
      past_valid  <= 1'b0;
    end else begin
      past_valid <= search;
      if (search) begin
        past_output <= rd_data;
      end
    end
  end

  assign full       = (state == ST_FULL);
  assign fill_count = fill;

endmodule

// File: tb/tb_team_06_sample_history.sv
// Testbench for team_06_sample_history (DEPTH = 16, OFFSET_W = 5).
// The reference model keeps the held history as a queue (newest at the back)
// plus a plain array of every word ever written, used for stale reads when
// TEAM_06_HISTORY_ZERO_FILL_EN is undefined.

module tb_team_06_sample_history;

  localparam int DEPTH    = 16;
  localparam int OFFSET_W = 5;
  localparam int ADDR_W   = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [7:0]          save_audio = 8'h00;
  logic                save_en = 1'b0;
  logic                flush = 1'b0;
  logic                search = 1'b0;
  logic [OFFSET_W-1:0] offset = '0;
  logic [7:0]          past_output;
  logic                past_valid;
  logic                full;
  logic [ADDR_W:0]     fill_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] hist[$];
  logic [7:0] mmem [DEPTH];
  bit         mwritten [DEPTH];
  int         mptr = 0;
  logic [7:0] exp_out = 8'h00;
  bit         exp_known = 1'b1;
  bit         exp_valid = 1'b0;

  team_06_sample_history #(
    .DEPTH   (DEPTH),
    .OFFSET_W(OFFSET_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .save_audio (save_audio),
    .save_en    (save_en),
    .flush      (flush),
    .search     (search),
    .offset     (offset),
    .past_output(past_output),
    .past_valid (past_valid),
    .full       (full),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  // Value a read `off` samples back should return, from the model state.
  task automatic model_read(input int off, output logic [7:0] v, output bit k);
    if (off < hist.size()) begin
      v = hist[hist.size() - 1 - off];
      k = 1'b1;
    end else begin
`ifdef TEAM_06_HISTORY_ZERO_FILL_EN
      v = 8'h00;
      k = 1'b1;
`else
      int a;
      a = (((mptr - 1 - off) % DEPTH) + DEPTH) % DEPTH;
      v = mmem[a];
      k = mwritten[a];
`endif
    end
  endtask

  // Drive one cycle of stimulus, predict the read, then advance the model.
  task automatic cycle(input bit se, input logic [7:0] d, input bit fl,
                       input bit sr, input int off);
    logic [7:0] v;
    bit         k;
    save_audio = d;
    save_en    = se;
    flush      = fl;
    search     = sr;
    offset     = off[OFFSET_W-1:0];
    if (sr) begin
      model_read(off, v, k);
      exp_out   = v;
      exp_known = k;
    end
    exp_valid = sr;
    @(posedge clk);
    #1;
    if (fl) begin
      hist.delete();
      mptr = 0;
    end
    if (se) begin
      mmem[mptr]     = d;
      mwritten[mptr] = 1'b1;
      hist.push_back(d);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      mptr = (mptr + 1) % DEPTH;
    end
    save_en = 1'b0;
    flush   = 1'b0;
    search  = 1'b0;
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
    rst     = 1'b1;
    save_en = 1'b0;
    flush   = 1'b0;
    search  = 1'b0;
    hist.delete();
    mptr      = 0;
    exp_out   = 8'h00;
    exp_known = 1'b1;
    exp_valid = 1'b0;
  endtask

  task automatic test_reset();
    // Write and search requests during reset must be ignored.
    save_en    = 1'b1;
    save_audio = 8'hEE;
    search     = 1'b1;
    do_reset(2);
    n_checks++;
    if (past_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid: got %b want 0", past_valid);
    end
    n_checks++;
    if (past_output !== 8'h00) begin
      n_errors++; $display("FAIL reset_output: got %h want 00", past_output);
    end
    n_checks++;
    if (fill_count !== 5'd0) begin
      n_errors++; $display("FAIL reset_fill: got %0d want 0", fill_count);
    end
    n_checks++;
    if (full !== 1'b0) begin
      n_errors++; $display("FAIL reset_full: got %b want 0", full);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 0);
    n_checks++;
    if (past_valid !== 1'b1) begin
      n_errors++; $display("FAIL empty_read_valid: got %b want 1", past_valid);
    end
    if (exp_known) begin
      n_checks++;
      if (past_output !== exp_out) begin
        n_errors++; $display("FAIL empty_read_data: got %h want %h", past_output, exp_out);
      end
    end
    n_checks++;
    if (fill_count !== 5'd0 || full !== 1'b0) begin
      n_errors++; $display("FAIL empty_read_fill: got %0d/%b want 0/0", fill_count, full);
    end
  endtask

  task automatic test_basic();
    logic [7:0] want [3];
    want[0] = 8'h33; want[1] = 8'h22; want[2] = 8'h11;
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1, i);
      n_checks++;
      if (past_valid !== 1'b1 || past_output !== want[i]) begin
        n_errors++;
        $display("FAIL basic_off%0d: got v=%b d=%h want v=1 d=%h", i, past_valid, past_output, want[i]);
      end
    end
    n_checks++;
    if (fill_count !== 5'd3) begin
      n_errors++; $display("FAIL basic_fill: got %0d want 3", fill_count);
    end
    // past_output holds once past_valid drops
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 0);
    n_checks++;
    if (past_valid !== 1'b0 || past_output !== 8'h11) begin
      n_errors++; $display("FAIL basic_hold: got v=%b d=%h want v=0 d=11", past_valid, past_output);
    end
  endtask

  task automatic test_same_cycle();
    cycle(1'b1, 8'h44, 1'b0, 1'b1, 0);
    n_checks++;
    if (past_valid !== 1'b1 || past_output !== 8'h33) begin
      n_errors++; $display("FAIL rbw_old: got v=%b d=%h want v=1 d=33", past_valid, past_output);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 0);
    n_checks++;
    if (past_valid !== 1'b1 || past_output !== 8'h44) begin
      n_errors++; $display("FAIL rbw_new: got v=%b d=%h want v=1 d=44", past_valid, past_output);
    end
    n_checks++;
    if (fill_count !== 5'd4) begin
      n_errors++; $display("FAIL rbw_fill: got %0d want 4", fill_count);
    end
  endtask

  task automatic test_wrap();
    int offs [4];
    offs[0] = 0; offs[1] = 15; offs[2] = 16; offs[3] = 31;
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0, 0);
      n_checks++;
      if (full !== (i >= DEPTH - 1) || fill_count !== 5'((i + 1 < DEPTH) ? i + 1 : DEPTH)) begin
        n_errors++;
        $display("FAIL wrap_fill_%0d: got %0d/%b want %0d/%b", i, fill_count, full,
                 (i + 1 < DEPTH) ? i + 1 : DEPTH, (i >= DEPTH - 1));
      end
    end
    for (int j = 0; j < 4; j++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1, offs[j]);
      n_checks++;
      if (past_valid !== 1'b1) begin
        n_errors++; $display("FAIL wrap_valid_off%0d: got %b want 1", offs[j], past_valid);
      end
      if (exp_known) begin
        n_checks++;
        if (past_output !== exp_out) begin
          n_errors++; $display("FAIL wrap_off%0d: got %h want %h", offs[j], past_output, exp_out);
        end
      end
    end
  endtask

  task automatic test_flush();
    logic [7:0] last;
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      last = 8'($urandom);
      cycle(1'b1, last, 1'b0, 1'b0, 0);
    end
    // Flush, write and search together: the search sees pre-flush history.
    cycle(1'b1, 8'hA5, 1'b1, 1'b1, 0);
    n_checks++;
    if (past_valid !== 1'b1 || past_output !== last) begin
      n_errors++; $display("FAIL flush_pre: got v=%b d=%h want v=1 d=%h", past_valid, past_output, last);
    end
    n_checks++;
    if (fill_count !== 5'd1 || full !== 1'b0) begin
      n_errors++; $display("FAIL flush_fill: got %0d/%b want 1/0", fill_count, full);
    end
    for (int off = 0; off < 2; off++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1, off);
      if (exp_known) begin
        n_checks++;
        if (past_output !== exp_out) begin
          n_errors++; $display("FAIL flush_off%0d: got %h want %h", off, past_output, exp_out);
        end
      end
    end
    // Fill to FULL, then flush with no write back to empty.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 0);
    n_checks++;
    if (full !== 1'b1 || fill_count !== 5'd16) begin
      n_errors++; $display("FAIL flush_full_pre: got %0d/%b want 16/1", fill_count, full);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 0);
    n_checks++;
    if (full !== 1'b0 || fill_count !== 5'd0) begin
      n_errors++; $display("FAIL flush_empty: got %0d/%b want 0/0", fill_count, full);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 8'h77, 1'b0, 1'b0, 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 0);
    rst    = 1'b0;
    search = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (past_valid !== 1'b0 || past_output !== 8'h00) begin
      n_errors++; $display("FAIL midreset_out: got v=%b d=%h want v=0 d=00", past_valid, past_output);
    end
    do_reset(0);
    n_checks++;
    if (fill_count !== 5'd0 || full !== 1'b0) begin
      n_errors++; $display("FAIL midreset_fill: got %0d/%b want 0/0", fill_count, full);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 0);
    n_checks++;
    if (past_valid !== 1'b1) begin
      n_errors++; $display("FAIL midreset_read_valid: got %b want 1", past_valid);
    end
    if (exp_known) begin
      n_checks++;
      if (past_output !== exp_out) begin
        n_errors++; $display("FAIL midreset_read: got %h want %h", past_output, exp_out);
      end
    end
  endtask

  task automatic test_random();
    bit se, fl, sr;
    int off;
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      se  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 39) == 0);
      sr  = ($urandom_range(0, 2) != 0);
      off = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      cycle(se, 8'($urandom), fl, sr, off);
      n_checks++;
      if (past_valid !== exp_valid) begin
        n_errors++; $display("FAIL rand_valid_%0d: got %b want %b", i, past_valid, exp_valid);
      end
      if (exp_known) begin
        n_checks++;
        if (past_output !== exp_out) begin
          n_errors++; $display("FAIL rand_data_%0d: got %h want %h", i, past_output, exp_out);
        end
      end
      n_checks++;
      if (fill_count !== 5'(hist.size()) || full !== (hist.size() == DEPTH)) begin
        n_errors++;
        $display("FAIL rand_fill_%0d: got %0d/%b want %0d/%b", i, fill_count, full,
                 hist.size(), (hist.size() == DEPTH));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mmem[i]     = 8'h00;
      mwritten[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_same_cycle();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
